// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like arbiter onto one shared slave port. An order FIFO of
// source IDs steers each in-order slave response back to the issuing master.
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [OUTSTANDING-1:0] id_fifo;
  logic                   sel_data, sel_req, full, empty, push, pop, head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Master select: data wins in IDLE; a pending unaccepted request holds the lock.
  always_comb begin
    sel_data = 1'b0;
    case (state)
      IDLE:    sel_data = data_req;
      LOCK_D:  sel_data = 1'b1;
      default: sel_data = 1'b0;
    endcase
  end

  assign full    = (count == CNT_W'(OUTSTANDING));
  assign empty   = (count == '0);
  assign sel_req = sel_data ? data_req : inst_req;

  assign mem_req   = sel_req & ~full;
  assign mem_wr    = sel_data ? data_wr    : inst_wr;
  assign mem_size  = sel_data ? data_size  : inst_size;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wdata = sel_data ? data_wdata : inst_wdata;

  assign inst_addr_ok = ~sel_data & mem_addr_ok & ~full;
  assign data_addr_ok =  sel_data & mem_addr_ok & ~full;

  assign push    = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty;
  assign head_id = id_fifo[rd_ptr];

  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop &  head_id;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Lock is taken when the slave stalls and released on accept or request withdrawal.
  always_comb begin
    state_nxt = state;
    if (!full) begin
      case (state)
        IDLE:    if (mem_req && !mem_addr_ok) state_nxt = sel_data ? LOCK_D : LOCK_I;
        LOCK_I:  if (!inst_req || mem_addr_ok) state_nxt = IDLE;
        LOCK_D:  if (!data_req || mem_addr_ok) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Order FIFO; a response arriving while empty is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      id_fifo   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= sel_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_data_ok && empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inline request-side checks plus a
// scoreboard queue of expected responses consumed by an independent monitor.
module tb_sram_like_arbiter;

  logic        clk, reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];  // {source (1=data), rdata}

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1c00_0000; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0100; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic expect_resp(input logic src, input logic [31:0] d);
    exp_q.push_back({src, d});
  endtask

  // Drive on negedge; inline checks at +2, monitor samples at +4, posedge at +5.
  task automatic cyc();
    @(negedge clk);
    clear();
  endtask

  // Response monitor: every data_ok must match the head of the expected queue.
  always begin
    @(negedge clk);
    #4;
    if (inst_data_ok || data_data_ok) begin
      logic [32:0] e;
      check("data_ok_exclusive", 32'(inst_data_ok & data_data_ok), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_data_ok", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("resp_source", 32'(data_data_ok), 32'(e[32]));
        check("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear();
    cyc(); #2;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
    cyc(); reset = 1'b0; #2;
    check("post_rst_proto_err", 32'(proto_err), 0);
    check("post_rst_mem_req", 32'(mem_req), 0);
    check("post_rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);

    // Priority: both request, data wins
    cyc(); inst_req = 1; data_req = 1; mem_addr_ok = 1; #2;
    check("prio_mem_addr", mem_addr, 32'h0000_0100);
    check("prio_data_addr_ok", 32'(data_addr_ok), 1);
    check("prio_inst_addr_ok", 32'(inst_addr_ok), 0);
    cyc(); inst_req = 1; mem_addr_ok = 1; #2;
    check("prio_inst_second", 32'(inst_addr_ok), 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h1111_0001; expect_resp(1, 32'h1111_0001);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h2222_0002; expect_resp(0, 32'h2222_0002);

    // Lock: inst stalled, data arrives later, inst keeps the port
    cyc(); inst_req = 1; #2;
    check("lock_c0_mem_req", 32'(mem_req), 1);
    check("lock_c0_addr_ok", 32'(inst_addr_ok), 0);
    cyc(); inst_req = 1; data_req = 1; #2;
    check("lock_c1_mem_addr", mem_addr, 32'h1c00_0000);
    check("lock_c1_data_addr_ok", 32'(data_addr_ok), 0);
    cyc(); inst_req = 1; data_req = 1; mem_addr_ok = 1; #2;
    check("lock_c2_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("lock_c2_data_addr_ok", 32'(data_addr_ok), 0);
    cyc(); data_req = 1; mem_addr_ok = 1; #2;
    check("lock_c3_data_addr_ok", 32'(data_addr_ok), 1);
    check("lock_c3_mem_addr", mem_addr, 32'h0000_0100);

    // Full: two outstanding, third request blocked, same-cycle pop does not release
    cyc(); inst_req = 1; mem_addr_ok = 1; #2;
    check("full_mem_req", 32'(mem_req), 0);
    check("full_inst_addr_ok", 32'(inst_addr_ok), 0);
    cyc(); inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
    expect_resp(0, 32'hAAAA_0001); #2;
    check("full_pop_cycle_mem_req", 32'(mem_req), 0);
    check("full_pop_cycle_addr_ok", 32'(inst_addr_ok), 0);
    cyc(); inst_req = 1; mem_addr_ok = 1; inst_addr = 32'h1c00_0004; #2;
    check("full_release_addr_ok", 32'(inst_addr_ok), 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'hBBBB_0002; expect_resp(1, 32'hBBBB_0002);
    cyc(); mem_data_ok = 1; mem_rdata = 32'hCCCC_0003; expect_resp(0, 32'hCCCC_0003);

    // Lock withdrawn without acceptance, then a data write
    cyc(); inst_req = 1; #2;
    cyc(); data_req = 1; #2;
    check("withdraw_mem_req", 32'(mem_req), 0);
    cyc(); data_req = 1; data_wr = 1; data_size = 2'd1; data_wdata = 32'h5A5A_1234;
    mem_addr_ok = 1; #2;
    check("wr_data_addr_ok", 32'(data_addr_ok), 1);
    check("wr_mem_wr", 32'(mem_wr), 1);
    check("wr_mem_size", 32'(mem_size), 32'd1);
    check("wr_mem_wdata", mem_wdata, 32'h5A5A_1234);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h0; expect_resp(1, 32'h0);

    // Simultaneous push and pop
    cyc(); inst_req = 1; mem_addr_ok = 1;
    cyc(); data_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h4444_0001;
    expect_resp(0, 32'h4444_0001); #2;
    check("pushpop_data_addr_ok", 32'(data_addr_ok), 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h4444_0002; expect_resp(1, 32'h4444_0002);
    cyc(); #2;
    check("pushpop_no_proto_err", 32'(proto_err), 0);

    // Pop while empty with same-cycle push: pop ignored, flag set
    cyc(); inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; #2;
    check("empty_pop_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("empty_pop_no_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    cyc(); #2;
    check("empty_pop_proto_err", 32'(proto_err), 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h3333_0004; expect_resp(0, 32'h3333_0004);
    cyc(); #2;
    check("proto_err_sticky", 32'(proto_err), 1);

    // Reset with two outstanding discards them
    cyc(); inst_req = 1; data_req = 1; mem_addr_ok = 1;
    cyc(); inst_req = 1; mem_addr_ok = 1;
    cyc(); reset = 1;
    cyc(); reset = 0; #2;
    check("rst2_proto_err", 32'(proto_err), 0);
    check("rst2_mem_req", 32'(mem_req), 0);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h7777_7777; #2;
    check("rst2_stale_no_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    cyc(); inst_req = 1; mem_addr_ok = 1; #2;
    check("rst2_proto_err_set", 32'(proto_err), 1);
    check("rst2_accept1", 32'(inst_addr_ok), 1);
    cyc(); inst_req = 1; mem_addr_ok = 1; #2;
    check("rst2_accept2", 32'(inst_addr_ok), 1);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h8888_0001; expect_resp(0, 32'h8888_0001);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h8888_0002; expect_resp(0, 32'h8888_0002);

    cyc(); cyc(); cyc(); #2;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 Parameter: OUTSTANDING, 2, max accepted-but-unanswered transactions (range 1..4).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_req / inst_wr  in  1/1  instruction master request and write flag.
REQ-005 inst_size / inst_addr / inst_wdata  in  2/32/32  instruction master size code, address and write data.
REQ-006 inst_addr_ok / inst_data_ok  out  1/1  instruction master handshakes.
REQ-007 inst_rdata  out  32  instruction master read data.
REQ-008 data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  data master request fields.
REQ-009 data_addr_ok / data_data_ok / data_rdata  out  1/1/32  data master responses.
REQ-010 mem_req / mem_wr / mem_size / mem_addr / mem_wdata  out  1/1/2/32/32  shared slave request.
REQ-011 mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  shared slave responses.
REQ-012 proto_err  out  1  sticky flag for mem_data_ok received with no transaction outstanding.

Function
REQ-013 Arbitration FSM states: IDLE, LOCK_I, LOCK_D.
REQ-014 In IDLE, data_req has priority over inst_req; the selected master drives mem_wr/size/addr/wdata combinationally, and mem_req = selected master's req.
REQ-015 IDLE -> LOCK_D when data is selected and mem_req=1, mem_addr_ok=0; IDLE -> LOCK_I likewise for inst.
REQ-016 In LOCK_x, master x is selected unconditionally, even if the other master requests.
REQ-017 LOCK_x -> IDLE on the cycle mem_req & mem_addr_ok.
REQ-018 LOCK_x -> IDLE also when x deasserts req without acceptance; no transaction is recorded.
REQ-019 The selected master's addr_ok = mem_addr_ok & ~full; the unselected master's addr_ok = 0.
REQ-020 Order FIFO: depth OUTSTANDING, 1-bit source ID (0=inst, 1=data), plus a count register of width clog2(OUTSTANDING+1).
REQ-021 Push source ID on mem_req & mem_addr_ok & ~full.
REQ-022 Pop on mem_data_ok & ~empty; head ID routes data_ok: inst_data_ok = pop & head==0, data_data_ok = pop & head==1.
REQ-023 mem_rdata is driven to both inst_rdata and data_rdata unmodified; validity is qualified only by the per-master data_ok.
REQ-024 When full: mem_req forced to 0, both addr_ok = 0, FSM state held.
REQ-025 Simultaneous push and pop: count unchanged, pointers both advance, popped ID is the old head.
REQ-026 Push and pop occurring on the same cycle as empty->nonempty: a pop with count==0 is ignored even if a push occurs that cycle; proto_err set to 1.
REQ-027 Read and write pointers wrap modulo OUTSTANDING.
REQ-028 Write transactions are queued and answered identically to reads; the mem_data_ok for a write still routes to the issuing master.
REQ-029 The accept cycle has latency 0 (combinational addr_ok); the response has latency 0 from mem_data_ok to master data_ok.

Reset
REQ-030 On reset: FSM=IDLE, count=0, read/write pointers=0, proto_err=0.
REQ-031 Output values during and immediately after reset: mem_req=0 and all addr_ok/data_ok=0 while no master requests.
REQ-032 Reset mid-transaction discards all outstanding IDs; later mem_data_ok pulses set proto_err.

Verification
REQ-033 Priority: inst_req=1 and data_req=1 with mem_addr_ok=1 at the same cycle -> mem_addr=data_addr, data_addr_ok=1, inst_addr_ok=0, FIFO head=1.
REQ-034 Lock: inst_req=1 while mem_addr_ok=0 (cycle 0), data_req rises at cycle 1, mem_addr_ok=1 at cycle 2 -> inst accepted at cycle 2, data accepted at cycle 3.
REQ-035 Ordering: accept inst @0x1c000000, then data @0x00000100; return mem_data_ok with rdata 0xAAAA0001 then 0xBBBB0002 -> inst_data_ok with 0xAAAA0001 first, then data_data_ok with 0xBBBB0002.
REQ-036 Full: OUTSTANDING=2 and two accepted, a third req -> mem_req=0 and addr_ok=0 until the next mem_data_ok; the same-cycle pop does not release the full condition.
REQ-037 Error/reset: mem_data_ok with count=0 -> no data_ok and proto_err=1; reset with 2 outstanding -> count=0 and proto_err=0 next cycle.
